// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Encoding of the most recent burst winner, used to break ties.
  localparam logic WIN_A = 1'b0;
  localparam logic WIN_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the
// requester that did not win last time is granted. Purely combinational.
module rr_pick2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] req_i,      // {B, A}
  input  logic       last_win_i,
  output logic [1:0] grant_o     // one-hot {B, A}, 00 when no request
);

  // Tie goes to whoever did not win last; otherwise pass the request through.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11)
      grant_o = (last_win_i == WIN_A) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU (A) and load (B)
// writeback paths. Round-robin between bursts, locked within a burst,
// one-cycle registered write issue with optional r0 suppression.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = 8,
  parameter bit R0_ZERO   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_VALID,
  input  logic              A_LAST,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_READY,
  input  logic              B_VALID,
  input  logic              B_LAST,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [DATA_W-1:0] WDATA,
  output logic [1:0]        OWNER,
  output logic              BUSY
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_M1 = BW'(MAX_BURST - 1);

  arb_state_t        state_q;
  logic              last_win_q;
  logic [BW-1:0]     beats_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        grant;
  logic              a_xfer, b_xfer, xfer, terminal, sel_last;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_pick2 u_pick (
    .req_i      ({B_VALID, A_VALID}),
    .last_win_i (last_win_q),
    .grant_o    (grant)
  );

  // Ready generation: picker result in IDLE, locked owner otherwise,
  // nothing accepted while reset is asserted.
  always_comb begin
    A_READY = 1'b0;
    B_READY = 1'b0;
    if (!RST) begin
      unique case (state_q)
        IDLE:  begin A_READY = grant[0]; B_READY = grant[1]; end
        OWN_A: A_READY = 1'b1;
        OWN_B: B_READY = 1'b1;
        default: ;
      endcase
    end
  end

  assign a_xfer   = A_VALID & A_READY;
  assign b_xfer   = B_VALID & B_READY;
  assign xfer     = a_xfer | b_xfer;
  assign sel_last = b_xfer ? B_LAST : A_LAST;
  assign sel_addr = b_xfer ? B_ADDR : A_ADDR;
  assign sel_data = b_xfer ? B_DATA : A_DATA;
  // Burst ends on LAST or when the lock has used its beat budget.
  assign terminal = sel_last | (beats_q == BURST_M1);

  // Arbiter FSM, burst counter and registered write port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      last_win_q <= WIN_B;
      beats_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= xfer & ~(R0_ZERO & (sel_addr == '0));
      if (xfer) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
        if (terminal) begin
          state_q    <= IDLE;
          last_win_q <= b_xfer ? WIN_B : WIN_A;
          beats_q    <= '0;
        end else begin
          state_q <= b_xfer ? OWN_B : OWN_A;
          beats_q <= beats_q + BW'(1);
        end
      end
    end
  end

  assign WE    = we_q;
  assign WADDR = waddr_q;
  assign WDATA = wdata_q;
  assign OWNER = {state_q == OWN_B, state_q == OWN_A};
  assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write-issue scoreboard.
module tb_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        A_VALID, A_LAST, B_VALID, B_LAST;
  logic [4:0]  A_ADDR, B_ADDR;
  logic [31:0] A_DATA, B_DATA;
  logic        A_READY, B_READY, WE, BUSY;
  logic [4:0]  WADDR;
  logic [31:0] WDATA;
  logic [1:0]  OWNER;
  logic        A_READY0, B_READY0, WE0, BUSY0;
  logic [4:0]  WADDR0;
  logic [31:0] WDATA0;
  logic [1:0]  OWNER0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          kind;  // 0: no write, 1: write issued, 2: accepted but suppressed
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_BURST(8), .R0_ZERO(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_LAST(A_LAST), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_LAST(B_LAST), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .OWNER(OWNER), .BUSY(BUSY)
  );

  // Same stimulus, r0 writes passed through.
  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_BURST(8), .R0_ZERO(1'b0)) dut0 (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_LAST(A_LAST), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY0),
    .B_VALID(B_VALID), .B_LAST(B_LAST), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY0),
    .WE(WE0), .WADDR(WADDR0), .WDATA(WDATA0), .OWNER(OWNER0), .BUSY(BUSY0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive beats, check READY mid-cycle, push the expected write,
  // then after the edge pop it and compare against the write port.
  task automatic step(input logic av, input logic al, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic bl, input logic [4:0] ba, input logic [31:0] bd,
                      input logic ear, input logic ebr, input string tag);
    exp_t e;
    A_VALID = av; A_LAST = al; A_ADDR = aa; A_DATA = ad;
    B_VALID = bv; B_LAST = bl; B_ADDR = ba; B_DATA = bd;
    #1;
    chk({tag, " a_ready"}, A_READY, ear);
    chk({tag, " b_ready"}, B_READY, ebr);
    e.kind = 0; e.addr = '0; e.data = '0;
    if (av && ear) begin
      e.kind = (aa != 0) ? 1 : 2; e.addr = aa; e.data = ad;
    end else if (bv && ebr) begin
      e.kind = (ba != 0) ? 1 : 2; e.addr = ba; e.data = bd;
    end
    sb.push_back(e);
    @(posedge CLK); #1;
    e = sb.pop_front();
    chk({tag, " we"}, WE, e.kind == 1);
    if (e.kind == 1) begin
      chk({tag, " waddr"}, WADDR, e.addr);
      chk({tag, " wdata"}, WDATA, e.data);
    end
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    RST = 1'b1;
    A_VALID = 1'b1; A_LAST = 1'b1; A_ADDR = 5'd7; A_DATA = 32'h1;
    B_VALID = 1'b1; B_LAST = 1'b1; B_ADDR = 5'd8; B_DATA = 32'h2;
    #1;
    chk("rst a_ready", A_READY, 0);
    chk("rst b_ready", B_READY, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst we", WE, 0);
    chk("rst waddr", WADDR, 0);
    chk("rst wdata", WDATA, 0);
    chk("rst owner", OWNER, 2'b00);
    chk("rst busy", BUSY, 0);
    RST = 1'b0;

    // Single A beat, then hold.
    step(1, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, "single_a");
    idle("single_a_after");
    chk("hold waddr", WADDR, 5'd3);
    chk("hold wdata", WDATA, 32'hDEADBEEF);

    // Lone B beat; leaves B as last winner.
    step(0, 0, 0, 0, 1, 1, 5'd5, 32'h55, 0, 1, "single_b");

    // Tied single-beat streams alternate A,B,A,B.
    step(1, 1, 5'd1, 32'hA1, 1, 1, 5'd9,  32'hB9,  1, 0, "tie1");
    step(1, 1, 5'd2, 32'hA2, 1, 1, 5'd9,  32'hB9,  0, 1, "tie2");
    step(1, 1, 5'd2, 32'hA2, 1, 1, 5'd10, 32'hB10, 1, 0, "tie3");
    step(1, 1, 5'd3, 32'hA3, 1, 1, 5'd10, 32'hB10, 0, 1, "tie4");

    // Locked 3-beat A burst with B waiting, including an owner stall.
    step(1, 0, 5'd11, 32'h111, 1, 1, 5'd20, 32'h200, 1, 0, "burst1");
    chk("burst1 owner", OWNER, 2'b01);
    chk("burst1 busy", BUSY, 1);
    step(1, 0, 5'd12, 32'h112, 1, 1, 5'd20, 32'h200, 1, 0, "burst2");
    step(0, 0, 5'd13, 32'h113, 1, 1, 5'd20, 32'h200, 1, 0, "burst_stall");
    chk("stall owner", OWNER, 2'b01);
    step(1, 1, 5'd13, 32'h113, 1, 1, 5'd20, 32'h200, 1, 0, "burst3");
    chk("burst_end owner", OWNER, 2'b00);
    step(0, 0, 0, 0, 1, 1, 5'd20, 32'h200, 0, 1, "b_after_burst");

    // A never raises LAST: lock ends after 8 beats, B gets in, A resumes.
    for (int i = 1; i <= 8; i++)
      step(1, 0, 5'(i), 32'hC00 + i, 1, 1, 5'd21, 32'h210, 1, 0, $sformatf("max%0d", i));
    chk("max owner", OWNER, 2'b00);
    step(1, 0, 5'd9,  32'hC09, 1, 1, 5'd21, 32'h210, 0, 1, "max_b");
    step(1, 0, 5'd9,  32'hC09, 0, 0, 0, 0, 1, 0, "max_a9");
    chk("resume owner", OWNER, 2'b01);
    step(1, 1, 5'd10, 32'hC0A, 0, 0, 0, 0, 1, 0, "max_a10");

    // r0 write: accepted, suppressed in dut, issued in dut0.
    step(1, 1, 5'd0, 32'h1234, 0, 0, 0, 0, 1, 0, "r0");
    chk("r0 we0", WE0, 1);
    chk("r0 waddr0", WADDR0, 0);
    chk("r0 wdata0", WDATA0, 32'h1234);

    // Reset on the second beat of a B burst.
    step(0, 0, 0, 0, 1, 0, 5'd14, 32'hE1, 0, 1, "rstb1");
    chk("rstb1 owner", OWNER, 2'b10);
    RST = 1'b1;
    step(1, 1, 5'd15, 32'hF0, 1, 0, 5'd15, 32'hE2, 0, 0, "rstb2");
    chk("post_rst owner", OWNER, 2'b00);
    chk("post_rst waddr", WADDR, 0);
    chk("post_rst wdata", WDATA, 0);
    RST = 1'b0;
    step(1, 1, 5'd16, 32'hF1, 1, 1, 5'd17, 32'hE3, 1, 0, "post_rst_tie");
    idle("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
